// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one memory port between the IFU (read-only) and the LSU, with a WAIT watchdog.
// One transaction in flight; a zero-wait slave gives 3 cycles from accept to rsp_valid; req_ready is only raised in IDLE.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  input  logic                ifu_rsp_ready,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_rsp_valid,
  input  logic                lsu_rsp_ready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  output logic                mem_rsp_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_err
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic M_IFU = 1'b0;
  localparam logic M_LSU = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              gnt;
  logic              last;
  logic              sel;
  logic              accept;
  logic              rsp_done;
  logic              timeout;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rdata;
  logic              err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    sel           = M_IFU;
    accept        = 1'b0;
    rsp_done      = 1'b0;
    timeout       = 1'b0;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    lsu_rsp_valid = 1'b0;
    mem_req_valid = 1'b0;
    mem_rsp_ready = 1'b0;
    unique case (state)
      S_IDLE: begin
        // On a tie the master that did not win last time goes first.
        if (ifu_req_valid && lsu_req_valid) begin
          sel = ~last;
        end else begin
          sel = lsu_req_valid;
        end
        accept        = ifu_req_valid || lsu_req_valid;
        ifu_req_ready = ifu_req_valid && (sel == M_IFU);
        lsu_req_ready = lsu_req_valid && (sel == M_LSU);
        mem_rsp_ready = 1'b1;
        if (accept) begin
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        mem_rsp_ready = 1'b1;
        if (mem_rsp_valid) begin
          state_nxt = S_RESP;
        end else if (cnt == CNT_LAST) begin
          timeout   = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        ifu_rsp_valid = (gnt == M_IFU);
        lsu_rsp_valid = (gnt == M_LSU);
        rsp_done      = (gnt == M_LSU) ? lsu_rsp_ready : ifu_rsp_ready;
        if (rsp_done) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt       <= M_IFU;
      last      <= M_IFU;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_wen   <= 1'b0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      rdata     <= '0;
      err       <= 1'b0;
    end else begin
      if (accept) begin
        gnt <= sel;
        if (sel == M_LSU) begin
          mem_addr  <= lsu_addr;
          mem_wen   <= lsu_wen;
          mem_wdata <= lsu_wdata;
          mem_wmask <= lsu_wmask;
        end else begin
          mem_addr  <= ifu_addr;
          mem_wen   <= 1'b0;
          mem_wdata <= '0;
          mem_wmask <= '0;
        end
      end
      if (state == S_REQ && mem_req_ready) begin
        cnt <= '0;
      end
      // A real response on the last watchdog cycle still wins over the timeout.
      if (state == S_WAIT) begin
        if (mem_rsp_valid) begin
          rdata <= mem_rdata;
          err   <= mem_err;
        end else if (timeout) begin
          rdata <= '0;
          err   <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
      if (rsp_done) begin
        last <= gnt;
      end
    end
  end

  assign ifu_rdata = rdata;
  assign ifu_err   = err;
  assign lsu_rdata = rdata;
  assign lsu_err   = err;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, single-slave memory arbiter for the multi-cycle NPC core. It shares one memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). Requests are granted round-robin and carried through a four-state transaction sequencer. A watchdog returns an error response if the slave stalls. It sits between the IFU/LSU valid-ready interfaces and the single memory/SRAM port.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; wmask width is DATA_W/8
- TIMEOUT, 255, max cycles in WAIT before an error response (1..2^16-1)

Clock and reset: clock clk; reset rst, synchronous, active-high.

- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ifu_req_valid / ifu_req_ready  in / out  1  IFU request handshake
- ifu_addr  in  ADDR_W  IFU read address
- ifu_rsp_valid / ifu_rsp_ready  out / in  1  IFU response handshake
- ifu_rdata  out  DATA_W  IFU read data
- ifu_err  out  1  IFU error flag, valid with ifu_rsp_valid
- lsu_req_valid / lsu_req_ready  in / out  1  LSU request handshake
- lsu_addr  in  ADDR_W  LSU address
- lsu_wen  in  1  1 = write, 0 = read
- lsu_wdata  in  DATA_W  write data
- lsu_wmask  in  DATA_W/8  byte enables
- lsu_rsp_valid / lsu_rsp_ready  out / in  1  LSU response handshake
- lsu_rdata / lsu_err  out  DATA_W / 1  LSU response data and error flag
- mem_req_valid / mem_req_ready  out / in  1  slave request handshake
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  ADDR_W, 1, DATA_W, DATA_W/8  latched request fields
- mem_rsp_valid / mem_rsp_ready  in / out  1  slave response handshake
- mem_rdata / mem_err  in  DATA_W / 1  slave response data and error flag

## Operation
- States:
  - IDLE: accept one request.
  - REQ: present the request to the slave.
  - WAIT: await the slave response.
  - RESP: return the response to the granted master.
- Grant register `gnt` (0 = IFU, 1 = LSU). `last` register resets to IFU.
- IDLE grant rules:
  - Only one master valid: grant it.
  - Both valid: grant the master that is not `last`, so the LSU wins the first tie after reset.
- IDLE outputs:
  - Granted master's req_ready = 1, combinationally.
  - Non-granted master's req_ready = 0.
  - Both req_ready = 0 in every other state.
- Acceptance in IDLE:
  - Latch addr, wen, wdata and wmask into the mem_* registers. For the IFU: wen = 0, wdata = 0, wmask = 0.
  - Set `gnt` and go to REQ.
- REQ:
  - mem_req_valid = 1.
  - On mem_req_ready, go to WAIT and clear the watchdog counter.
- WAIT:
  - mem_rsp_ready = 1.
  - On mem_rsp_valid, latch mem_rdata and mem_err, then go to RESP.
  - Otherwise the counter increments. When counter == TIMEOUT-1 with no response, latch rdata = 0 and err = 1, then go to RESP.
- RESP:
  - Granted master's rsp_valid = 1, driving the latched rdata and err; the other master's rsp_valid = 0.
  - On that master's rsp_ready, set `last` = `gnt` and go to IDLE.
- mem_rsp_ready is also 1 in IDLE. A stray or late response (for example, after a timeout) is consumed and discarded; it never reaches a master.
- Response data must not change while rsp_valid is high.

## Timing
- Reset values:
  - state = IDLE, last = IFU, counter = 0.
  - All *_valid and *_ready outputs = 0, except mem_rsp_ready = 1 in IDLE.
  - mem_addr, mem_wdata, mem_wmask, mem_wen = 0.
  - rdata = 0, err = 0.
- Minimum latency with a zero-wait slave:
  - Acceptance at cycle 0.
  - mem_req_valid at cycle 1.
  - mem_rsp_ready at cycle 2.
  - rsp_valid at cycle 3.
  - Next acceptance possible at cycle 4.
- One outstanding transaction at a time; no overlap between masters.
- mem_* request fields are stable from cycle 1 until the REQ handshake completes.
- Reset asserted mid-transaction:
  - Returns to IDLE on the next edge and drops the transaction.
  - Neither master receives a response.
- Simultaneous events:
  - mem_rsp_valid in the same cycle the counter reaches TIMEOUT-1: the real response wins and err = mem_err.
  - A new request arriving in RESP waits; it is not accepted until IDLE.

## Test plan
- IFU read only, addr 0x8000_0000, slave returns 0x0000_0413 in 1 cycle -> ifu_rsp_valid at cycle 3, rdata 0x0000_0413, err 0, lsu_rsp_valid stays 0.
- LSU write addr 0x8000_0100, wdata 0xDEAD_BEEF, wmask 0xF -> mem_wen = 1 and fields stable through a 3-cycle mem_req_ready stall; lsu_rsp_valid with err 0.
- Both masters valid every cycle for 6 transactions after reset -> grant order LSU, IFU, LSU, IFU, LSU, IFU.
- Slave never responds, TIMEOUT = 4 -> RESP entered 4 cycles after the REQ handshake with err = 1, rdata 0. A late mem_rsp_valid in IDLE is consumed and no master sees it.
- Master holds rsp_ready = 0 for 5 cycles -> rsp_valid, rdata and err held constant; the other master's req_ready stays 0 throughout.
- rst pulsed while in WAIT -> next cycle state IDLE, all outputs at reset values, and a subsequent IFU read completes normally.
